// File: rtl/sd_cmd_frame_parser.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : sd_cmd_frame_parser                                          |
// | Description : Assembles 6-byte SD-in-SPI command frames from the SPI byte  |
// |               stream, checks CRC7 and presents cmd index + argument.       |
// | Revision    : 1.0  initial release                                         |
// +---------------------------------------------------------------------------+
module sd_cmd_frame_parser #(
    parameter int CHECK_CRC   = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        ssel_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_ok,
    output logic        frame_abort,
    output logic        overrun
);

    localparam int             c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t               r_state, w_state;
    logic [2:0]           r_cnt, w_cnt;
    logic [6:0]           r_crc, w_crc;
    logic [c_tmo_w-1:0]   r_tmo, w_tmo;
    logic [5:0]           r_index, w_index;
    logic [31:0]          r_arg, w_arg;
    logic                 r_crc_ok, w_crc_ok;
    logic                 r_valid, w_valid;
    logic                 r_abort, w_abort;
    logic                 r_ovr, w_ovr;
    logic                 w_start;
    logic [6:0]           w_crc_first;
    logic [6:0]           w_crc_next;

    // CRC7 (x^7 + x^3 + 1), one byte processed MSB first
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
        end
        return c;
    endfunction

    assign w_start     = (rx_data[7:6] == 2'b01);
    assign w_crc_first = crc7_byte(7'd0, rx_data);
    assign w_crc_next  = crc7_byte(r_crc, rx_data);

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_crc    = r_crc;
        w_tmo    = r_tmo;
        w_index  = r_index;
        w_arg    = r_arg;
        w_crc_ok = r_crc_ok;
        w_valid  = r_valid;
        w_abort  = 1'b0;
        w_ovr    = 1'b0;
        case (r_state)
            HUNT: begin
                if (rx_valid && w_start && !ssel_n) begin
                    w_index = rx_data[5:0];
                    w_crc   = w_crc_first;
                    w_cnt   = 3'd1;
                    w_tmo   = '0;
                    w_state = COLLECT;
                end
            end
            COLLECT: begin
                // Deselection takes priority over a byte arriving in the same cycle
                if (ssel_n) begin
                    w_abort = 1'b1;
                    w_state = HUNT;
                    w_cnt   = 3'd0;
                    w_crc   = 7'd0;
                    w_tmo   = '0;
                end else if (rx_valid) begin
                    w_tmo = '0;
                    if (r_cnt == 3'd5) begin
                        w_crc_ok = (CHECK_CRC != 0) ? ((rx_data[7:1] == r_crc) && rx_data[0]) : 1'b1;
                        w_valid  = 1'b1;
                        w_state  = HOLD;
                        w_cnt    = 3'd0;
                        w_crc    = 7'd0;
                    end else begin
                        w_arg = {r_arg[23:0], rx_data};
                        w_crc = w_crc_next;
                        w_cnt = r_cnt + 3'd1;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_abort = 1'b1;
                    w_state = HUNT;
                    w_cnt   = 3'd0;
                    w_crc   = 7'd0;
                    w_tmo   = '0;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            HOLD: begin
                // Completed frame is kept regardless of ssel_n; incoming bytes are dropped
                if (rx_valid && w_start) begin
                    w_ovr = 1'b1;
                end
                if (cmd_ready) begin
                    w_valid = 1'b0;
                    w_state = HUNT;
                end
            end
            default: begin
                w_state = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= HUNT;
            r_cnt    <= 3'd0;
            r_crc    <= 7'd0;
            r_tmo    <= '0;
            r_index  <= 6'd0;
            r_arg    <= 32'd0;
            r_crc_ok <= 1'b0;
            r_valid  <= 1'b0;
            r_abort  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_crc    <= w_crc;
            r_tmo    <= w_tmo;
            r_index  <= w_index;
            r_arg    <= w_arg;
            r_crc_ok <= w_crc_ok;
            r_valid  <= w_valid;
            r_abort  <= w_abort;
            r_ovr    <= w_ovr;
        end
    end

    assign cmd_valid   = r_valid;
    assign cmd_index   = r_index;
    assign cmd_arg     = r_arg;
    assign cmd_crc_ok  = r_crc_ok;
    assign frame_abort = r_abort;
    assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_frame_parser.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_sd_cmd_frame_parser                                       |
// | Description : Directed self-checking bench for sd_cmd_frame_parser.        |
// | Revision    : 1.0  initial release                                         |
// +---------------------------------------------------------------------------+
module tb_sd_cmd_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ssel_n;
    logic        cmd_ready;
    logic        cmd_valid, cmd_crc_ok, frame_abort, overrun;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        nc_valid, nc_crc_ok, nc_abort, nc_overrun;
    logic [5:0]  nc_index;
    logic [31:0] nc_arg;

    int n_check = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_abort = 0;
    int n_ovr   = 0;
    int n_hs    = 0;
    int base_abort, base_ovr, base_hs;
    logic [38:0] exp_q[$];   // {index, arg, crc_ok}
    logic [38:0] exp_item;

    always #5 clk = ~clk;

    sd_cmd_frame_parser #(.CHECK_CRC(1), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .ssel_n(ssel_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_crc_ok(cmd_crc_ok), .frame_abort(frame_abort), .overrun(overrun)
    );

    sd_cmd_frame_parser #(.CHECK_CRC(0), .TIMEOUT_CYC(16)) dut_nc (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .ssel_n(ssel_n),
        .cmd_valid(nc_valid), .cmd_ready(cmd_ready), .cmd_index(nc_index), .cmd_arg(nc_arg),
        .cmd_crc_ok(nc_crc_ok), .frame_abort(nc_abort), .overrun(nc_overrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and scoreboard pop at each handshake
    always @(negedge clk) begin
        if (rst) begin
            if (frame_abort) n_abort++;
            if (overrun)     n_ovr++;
            if (cmd_valid && cmd_ready) begin
                n_hs++;
                check("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    check("sb_frame", {cmd_index, cmd_arg, cmd_crc_ok}, exp_item);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] idx,
                              input logic [31:0] arg, input logic ok);
        check({tag, "_valid"}, cmd_valid, 1);
        check({tag, "_index"}, cmd_index, idx);
        check({tag, "_arg"},   cmd_arg,   arg);
        check({tag, "_crcok"}, cmd_crc_ok, ok);
    endtask

    task automatic frame_test(input string tag, input logic [47:0] f, input logic [5:0] idx,
                              input logic [31:0] arg, input logic ok);
        exp_q.push_back({idx, arg, ok});
        for (int i = 5; i >= 0; i--) send(f[i*8 +: 8]);
        expect_out(tag, idx, arg, ok);
    endtask

    task automatic accept();
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        check("valid_drop", cmd_valid, 0);
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ssel_n = 1'b1; cmd_ready = 1'b0;
        tick(2);
        check("rst_valid", cmd_valid, 0);
        check("rst_index", cmd_index, 0);
        check("rst_arg", cmd_arg, 0);
        check("rst_crcok", cmd_crc_ok, 0);
        check("rst_abort", frame_abort, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1; ssel_n = 1'b0;
        tick(1);

        // CMD0 with valid CRC; cmd_valid must be high right after the 6th byte edge
        frame_test("cmd0", 48'h40_00_00_00_00_95, 6'd0, 32'h0, 1'b1);
        accept();

        // Fill bytes precede CMD8
        send(8'hFF); send(8'hFF);
        frame_test("cmd8", 48'h48_00_00_01_AA_87, 6'd8, 32'h0000_01AA, 1'b1);
        accept();

        // A 12-cycle gap inside a frame stays below the 16-cycle timeout
        exp_q.push_back({6'd0, 32'h0, 1'b1});
        send(8'h40); send(8'h00); send(8'h00);
        tick(12);
        send(8'h00); send(8'h00); send(8'h95);
        expect_out("cmd0_gap", 6'd0, 32'h0, 1'b1);
        accept();

        // Wrong CRC: still presented, crc_ok low unless checking is disabled
        frame_test("cmd17_bad", 48'h51_00_00_00_00_54, 6'd17, 32'h0, 1'b0);
        check("cmd17_nocheck_crcok", nc_crc_ok, 1);
        accept();

        // Deselect mid-frame, with a byte in the same cycle
        base_abort = n_abort;
        send(8'h40); send(8'h00); send(8'h00);
        @(posedge clk); #1;
        ssel_n = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("ssel_abort_pulse", frame_abort, 1);
        tick(1);
        ssel_n = 1'b0;
        tick(2);
        check("ssel_abort_count", n_abort - base_abort, 1);
        check("ssel_no_valid", cmd_valid, 0);
        frame_test("cmd0_after_abort", 48'h40_00_00_00_00_95, 6'd0, 32'h0, 1'b1);
        accept();

        // Inter-byte timeout
        base_abort = n_abort;
        send(8'h48); send(8'h00);
        tick(20);
        check("tmo_abort_count", n_abort - base_abort, 1);
        check("tmo_no_valid", cmd_valid, 0);
        frame_test("cmd0_after_tmo", 48'h40_00_00_00_00_95, 6'd0, 32'h0, 1'b1);
        accept();

        // Backpressure: held frame stays stable; start-pattern bytes (0x77, 0x65) pulse overrun
        base_ovr = n_ovr;
        frame_test("cmd0_held", 48'h40_00_00_00_00_95, 6'd0, 32'h0, 1'b1);
        send(8'h77);
        check("overrun_pulse", overrun, 1);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h65);
        tick(1);
        check("overrun_count", n_ovr - base_ovr, 2);
        expect_out("held_stable", 6'd0, 32'h0, 1'b1);
        base_hs = n_hs;
        accept();
        tick(2);
        check("held_one_handshake", n_hs - base_hs, 1);

        // Start byte coincident with the handshake is dropped with overrun
        frame_test("cmd8_hs", 48'h48_00_00_01_AA_87, 6'd8, 32'h0000_01AA, 1'b1);
        base_ovr = n_ovr;
        @(posedge clk); #1;
        cmd_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h40;
        @(posedge clk); #1;
        cmd_ready = 1'b0; rx_valid = 1'b0;
        check("hs_overrun_pulse", overrun, 1);
        check("hs_valid_drop", cmd_valid, 0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h95);
        tick(2);
        check("hs_no_frame", cmd_valid, 0);
        check("hs_overrun_count", n_ovr - base_ovr, 1);

        // Asynchronous reset mid-frame clears state without a clock edge or abort pulse
        base_abort = n_abort;
        send(8'h51); send(8'h00);
        #2 rst = 1'b0;
        #1;
        check("async_rst_index", cmd_index, 0);
        check("async_rst_arg", cmd_arg, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(1);
        frame_test("cmd0_after_rst", 48'h40_00_00_00_00_95, 6'd0, 32'h0, 1'b1);
        accept();
        tick(2);
        check("rst_no_abort", n_abort - base_abort, 0);
        check("sb_drained", exp_q.size(), 0);
        check("total_handshakes", n_hs, 9);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
